// File: rtl/io_pkg.sv
// Shared I/O constants: clock rate and switch debouncer defaults.
// No ports; imported by the sw_debounce files.
package io_pkg;

    localparam int CLK_HZ              = 50000000;
    localparam int SW_NUM_CH_DEF       = 16;
    localparam int SW_DEBOUNCE_CYC_DEF = 1000000;
    localparam int SW_CNT_W_DEF        = 20;

endpackage

// File: rtl/sw_debounce_if.sv
// Change-event handshake between the debouncer and its consumer.
// master: drives chg_valid/chg_mask, reads chg_ready; slave: reverse.
interface sw_debounce_if
    import io_pkg::*;
#(
    parameter int NUM_CH = SW_NUM_CH_DEF
);

    logic              chg_valid;
    logic [NUM_CH-1:0] chg_mask;
    logic              chg_ready;

    modport master (
        output chg_valid,
        output chg_mask,
        input  chg_ready
    );

    modport slave (
        input  chg_valid,
        input  chg_mask,
        output chg_ready
    );

endinterface

// File: rtl/sw_debounce_ch.sv
// One debounced switch channel: 2-flop sync, stability counter, level.
// Ports: clk_i, rst_ni, i_sw (raw), o_sw (debounced), o_upd (strobe),
//        o_rise/o_fall (edge pulses, only with SW_DEBOUNCE_EDGE_EN).
module sw_debounce_ch
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYC = SW_DEBOUNCE_CYC_DEF,
    parameter int CNT_W        = SW_CNT_W_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_sw,
    output logic o_sw,
    output logic o_upd,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sw;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_upd;

    assign w_diff = r_sync2 ^ r_sw;
    assign w_upd  = w_diff && (r_cnt == CNT_END);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sw    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            // Any return to the current level restarts the stability count.
            if (!w_diff || w_upd) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_upd) begin
                r_sw <= r_sync2;
            end
        end
    end

    assign o_sw  = r_sw;
    assign o_upd = w_upd;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Registered from the strobe so the pulse lines up with the new o_sw.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_upd & r_sync2;
            r_fall <= w_upd & ~r_sync2;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer with a sticky change-event handshake.
// Ports: clk_i, rst_ni, sw_i, sw_o, rise_o, fall_o, chg (master modport).
// Edge pulses are built only when SW_DEBOUNCE_EDGE_EN is defined.
module sw_debounce
    import io_pkg::*;
#(
    parameter int NUM_CH       = SW_NUM_CH_DEF,
    parameter int DEBOUNCE_CYC = SW_DEBOUNCE_CYC_DEF,
    parameter int CNT_W        = SW_CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] sw_i,
    output logic [NUM_CH-1:0] sw_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    sw_debounce_if.master     chg
);

    logic [NUM_CH-1:0] w_upd;
    logic [NUM_CH-1:0] r_pend;
    logic              w_valid;
    logic              w_accept;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sw_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .i_sw   (sw_i[g]),
            .o_sw   (sw_o[g]),
            .o_upd  (w_upd[g]),
            .o_rise (rise_o[g]),
            .o_fall (fall_o[g])
        );
    end

    assign w_valid  = |r_pend;
    assign w_accept = w_valid && chg.chg_ready;

    // On accept, reload with this cycle's strobes so none are dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pend <= '0;
        end else if (w_accept) begin
            r_pend <= w_upd;
        end else begin
            r_pend <= r_pend | w_upd;
        end
    end

    assign chg.chg_valid = w_valid;
    assign chg.chg_mask  = r_pend;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce (16 ch, DEBOUNCE_CYC=4, CNT_W=3).
// Inputs change 1 time unit after a rising edge; outputs sampled there.
module tb_sw_debounce;

`ifdef SW_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_ni;
    logic [15:0] sw_i;
    logic [15:0] sw_o;
    logic [15:0] rise_o;
    logic [15:0] fall_o;

    int n_vec;
    int n_err;

    sw_debounce_if #(.NUM_CH(16)) u_if ();

    sw_debounce #(
        .NUM_CH       (16),
        .DEBOUNCE_CYC (4),
        .CNT_W        (3)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .sw_i   (sw_i),
        .sw_o   (sw_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .chg    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] edge_exp(input logic [15:0] v);
        return EDGE_EN ? v : 16'h0000;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_ni = 1'b0;
        sw_i = 16'hFFFF;
        u_if.chg_ready = 1'b0;

        // Reset with all raw inputs high
        tick();
        tick();
        check("rst_sw", 32'(sw_o), 32'h0);
        check("rst_rise", 32'(rise_o), 32'h0);
        check("rst_fall", 32'(fall_o), 32'h0);
        check("rst_valid", 32'(u_if.chg_valid), 32'h0);
        check("rst_mask", 32'(u_if.chg_mask), 32'h0);

        rst_ni = 1'b1;
        sw_i = 16'h0000;
        for (int i = 0; i < 4; i++) tick();
        check("idle_sw", 32'(sw_o), 32'h0);
        check("idle_valid", 32'(u_if.chg_valid), 32'h0);

        // Clean rise on ch3: visible at edge 6
        sw_i = 16'h0008;
        for (int i = 0; i < 5; i++) tick();
        check("rise3_e5_sw", 32'(sw_o), 32'h0);
        check("rise3_e5_rise", 32'(rise_o), 32'h0);
        tick();
        check("rise3_e6_sw", 32'(sw_o), 32'h0008);
        check("rise3_e6_rise", 32'(rise_o), 32'(edge_exp(16'h0008)));
        check("rise3_e6_fall", 32'(fall_o), 32'h0);
        check("rise3_e6_valid", 32'(u_if.chg_valid), 32'h1);
        check("rise3_e6_mask", 32'(u_if.chg_mask), 32'h0008);
        tick();
        check("rise3_e7_rise", 32'(rise_o), 32'h0);
        check("rise3_e7_sw", 32'(sw_o), 32'h0008);

        // Backpressure: ch5 rises while 0x0008 is still pending
        sw_i = 16'h0028;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_mask", 32'(u_if.chg_mask), 32'h0008);
            check("bp_hold_valid", 32'(u_if.chg_valid), 32'h1);
        end
        tick();
        check("bp_add_mask", 32'(u_if.chg_mask), 32'h0028);
        check("bp_add_valid", 32'(u_if.chg_valid), 32'h1);
        check("bp_add_sw", 32'(sw_o), 32'h0028);
        u_if.chg_ready = 1'b1;
        tick();
        check("bp_acc_valid", 32'(u_if.chg_valid), 32'h0);
        check("bp_acc_mask", 32'(u_if.chg_mask), 32'h0);
        tick();
        check("rdy_idle_valid", 32'(u_if.chg_valid), 32'h0);
        u_if.chg_ready = 1'b0;

        // Simultaneous: ch5 falls, ch1 rises one edge later during accept
        sw_i = 16'h0008;
        tick();
        sw_i = 16'h000A;
        for (int i = 0; i < 4; i++) tick();
        check("sim_e5_sw", 32'(sw_o), 32'h0028);
        tick();
        check("sim_e6_sw", 32'(sw_o), 32'h0008);
        check("sim_e6_fall", 32'(fall_o), 32'(edge_exp(16'h0020)));
        check("sim_e6_mask", 32'(u_if.chg_mask), 32'h0020);
        u_if.chg_ready = 1'b1;
        tick();
        check("sim_e7_sw", 32'(sw_o), 32'h000A);
        check("sim_e7_rise", 32'(rise_o), 32'(edge_exp(16'h0002)));
        check("sim_e7_fall", 32'(fall_o), 32'h0);
        check("sim_e7_valid", 32'(u_if.chg_valid), 32'h1);
        check("sim_e7_mask", 32'(u_if.chg_mask), 32'h0002);
        tick();
        check("sim_e8_valid", 32'(u_if.chg_valid), 32'h0);
        u_if.chg_ready = 1'b0;

        // Bounce on ch0: high 3, low 1, then held high
        sw_i = 16'h000B;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bnc_sw", 32'(sw_o), 32'h000A);
        end
        sw_i = 16'h000A;
        tick();
        check("bnc_sw", 32'(sw_o), 32'h000A);
        sw_i = 16'h000B;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bnc_sw", 32'(sw_o), 32'h000A);
            check("bnc_rise", 32'(rise_o), 32'h0);
            check("bnc_valid", 32'(u_if.chg_valid), 32'h0);
        end
        tick();
        check("bnc_upd_sw", 32'(sw_o), 32'h000B);
        check("bnc_upd_rise", 32'(rise_o), 32'(edge_exp(16'h0001)));
        check("bnc_upd_mask", 32'(u_if.chg_mask), 32'h0001);
        tick();
        check("bnc_post_rise", 32'(rise_o), 32'h0);
        check("bnc_post_sw", 32'(sw_o), 32'h000B);
        u_if.chg_ready = 1'b1;
        tick();
        check("bnc_acc_valid", 32'(u_if.chg_valid), 32'h0);
        u_if.chg_ready = 1'b0;

        // Mid-count reset: ch2 counter reaches 2, then reset
        sw_i = 16'h000F;
        for (int i = 0; i < 4; i++) tick();
        check("mrst_pre_sw", 32'(sw_o), 32'h000B);
        rst_ni = 1'b0;
        tick();
        check("mrst_sw", 32'(sw_o), 32'h0);
        check("mrst_valid", 32'(u_if.chg_valid), 32'h0);
        check("mrst_mask", 32'(u_if.chg_mask), 32'h0);
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mrst_wait_sw", 32'(sw_o), 32'h0);
        end
        tick();
        check("mrst_e6_sw", 32'(sw_o), 32'h000F);
        check("mrst_e6_rise", 32'(rise_o), 32'(edge_exp(16'h000F)));
        check("mrst_e6_valid", 32'(u_if.chg_valid), 32'h1);
        check("mrst_e6_mask", 32'(u_if.chg_mask), 32'h000F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 16, giving the number of switch channels (1..32).
REQ-002 The module SHALL have parameter DEBOUNCE_CYC, default 1000000 (20 ms at 50 MHz), giving the required stable cycles (>=1).
REQ-003 The module SHALL have parameter CNT_W, default 20, giving the counter width; DEBOUNCE_CYC SHALL be < 2**CNT_W.
REQ-004 clk_i  input  1  single clock (CLOCK_50 domain).
REQ-005 rst_ni  input  1  reset; synchronous, active-low.
REQ-006 sw_i  input  NUM_CH  raw asynchronous switch levels.
REQ-007 sw_o  output  NUM_CH  debounced switch levels.
REQ-008 rise_o  output  NUM_CH  one-cycle pulse when sw_o bit goes 0->1.
REQ-009 fall_o  output  NUM_CH  one-cycle pulse when sw_o bit goes 1->0.
REQ-010 chg_valid_o  output  1  change event pending.
REQ-011 chg_mask_o  output  NUM_CH  channels changed since last accept.
REQ-012 chg_ready_i  input  1  consumer accepts pending change event.

Function
REQ-013 Each channel SHALL pass sw_i through a two-flop synchroniser before any other use.
REQ-014 Each channel SHALL keep a CNT_W-bit counter, cleared whenever the synchronised level equals sw_o, and otherwise incremented every cycle.
REQ-015 When the synchronised level differs from sw_o and the counter equals DEBOUNCE_CYC-1, sw_o SHALL take the synchronised level and the counter SHALL clear, both on the same edge.
REQ-016 Latency: with edge 1 the first edge sampling a new held level, sw_o SHALL update on edge DEBOUNCE_CYC+2.
REQ-017 A glitch shorter than DEBOUNCE_CYC synchronised cycles SHALL produce no change on sw_o, rise_o, fall_o or chg_mask_o.
REQ-018 rise_o/fall_o SHALL be registered and asserted for exactly the cycle in which the new sw_o value is first visible.
REQ-019 A pending register SHALL OR in every channel's update strobe each cycle; chg_mask_o SHALL equal the pending register; chg_valid_o SHALL equal its reduction-OR.
REQ-020 While chg_valid_o=1 and chg_ready_i=0, pending bits SHALL never clear; new events SHALL add bits.
REQ-021 On chg_valid_o=1 and chg_ready_i=1, pending SHALL load only the update strobes of that same cycle, so a simultaneous event is never lost.
REQ-022 chg_ready_i while chg_valid_o=0 SHALL have no effect.
REQ-023 Several channels updating on the same edge SHALL all appear in chg_mask_o together.

Reset
REQ-024 While rst_ni=0 at a clock edge, synchronisers, counters, sw_o, rise_o, fall_o and pending SHALL clear to 0, and chg_valid_o SHALL be 0.
REQ-025 Reset asserted mid-count SHALL discard the partial count; after release, a held level SHALL require the full DEBOUNCE_CYC+2 edges again.

Configuration
REQ-026 With macro SW_DEBOUNCE_EDGE_EN defined, rise_o and fall_o SHALL behave per REQ-018.
REQ-027 Without SW_DEBOUNCE_EDGE_EN, rise_o and fall_o SHALL remain as ports, be driven constant 0, and their registers SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-028 Shared package io_pkg SHALL hold the defaults SW_NUM_CH_DEF=16, SW_DEBOUNCE_CYC_DEF=1000000 and SW_CNT_W_DEF=20, plus the clock-frequency constant CLK_HZ=50000000.
REQ-029 One sub-module sw_debounce_ch (synchroniser, counter, sw_o bit, update strobe, edge pulses) SHALL be instantiated NUM_CH times by generate; pending/handshake logic SHALL stay in sw_debounce.

Verification (NUM_CH=16, DEBOUNCE_CYC=4, CNT_W=3)
REQ-030 Reset: rst_ni=0 for 2 cycles with sw_i=0xFFFF -> sw_o=0, rise_o=fall_o=0, chg_valid_o=0.
REQ-031 Clean rise: sw_i[3] 0->1 held -> sw_o[3]=1 at edge 6, rise_o=0x0008 for one cycle, chg_valid_o=1, chg_mask_o=0x0008.
REQ-032 Bounce: synchronised sw_i[0] high 3 cycles, low 1, then high held -> no update until 4 consecutive high cycles, exactly one rise_o[0] pulse.
REQ-033 Backpressure: pending 0x0008, chg_ready_i=0 for 5 cycles with ch5 update -> mask 0x0008 then 0x0028, valid held; chg_ready_i=1 -> valid=0 next cycle.
REQ-034 Simultaneous: accept in the same cycle ch1 updates -> next cycle chg_valid_o=1, chg_mask_o=0x0002.
REQ-035 Mid-count reset: ch2 counter at 2, rst_ni=0 one cycle, sw_i[2] held 1 -> sw_o[2] rises 6 edges after release, not earlier.
